// File: rtl/multdiv_ctrl_if.sv
// Execute-stage bundle between the pipeline, the mult/div unit
// and the register-file write port.
interface multdiv_ctrl_if;
  logic        in_valid;
  logic [4:0]  OP;
  logic [4:0]  ALUOP;
  logic [4:0]  rd_in;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic [31:0] md_opA;
  logic [31:0] md_opB;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_rdy;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception;

  modport master (
    input  in_valid, OP, ALUOP, rd_in,
    input  opA, opB,
    input  md_result, md_exception, md_rdy,
    output md_ctrl_mult, md_ctrl_div,
    output md_opA, md_opB,
    output stall,
    output wb_valid, wb_rd, wb_data,
    output wb_exception
  );

  modport slave (
    output in_valid, OP, ALUOP, rd_in,
    output opA, opB,
    output md_result, md_exception, md_rdy,
    input  md_ctrl_mult, md_ctrl_div,
    input  md_opA, md_opB,
    input  stall,
    input  wb_valid, wb_rd, wb_data,
    input  wb_exception
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared multi-cycle mul/div unit: decode, start,
// stall until ready or watchdog, then a one-cycle writeback.
module multdiv_ctrl #(
  parameter int TIMEOUT = 64
) (
  input logic          clock,
  input logic          reset,
  multdiv_ctrl_if.master bus
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_opA;
  logic [31:0]   r_opB;
  logic [4:0]    r_rd;
  logic          r_mult;
  logic          r_div;
  logic          r_wb_valid;
  logic [4:0]    r_wb_rd;
  logic [31:0]   r_wb_data;
  logic          r_wb_exc;

  logic w_rtype;
  logic w_is_mul;
  logic w_is_div;
  logic w_accept;
  logic w_timeout;

  assign w_rtype   = bus.in_valid & (bus.OP == 5'b00000);
  assign w_is_mul  = w_rtype & (bus.ALUOP == 5'b00110);
  assign w_is_div  = w_rtype & (bus.ALUOP == 5'b00111);
  assign w_accept  = (r_state == IDLE) & (w_is_mul | w_is_div);
  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_opA      <= '0;
      r_opB      <= '0;
      r_rd       <= '0;
      r_mult     <= 1'b0;
      r_div      <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_wb_exc   <= 1'b0;
    end else begin
      r_mult     <= 1'b0;
      r_div      <= 1'b0;
      r_wb_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_opA   <= bus.opA;
            r_opB   <= bus.opB;
            r_rd    <= bus.rd_in;
            r_cnt   <= '0;
            r_mult  <= w_is_mul;
            r_div   <= w_is_div;
            r_state <= START;
          end
        end
        START: r_state <= WAIT;
        WAIT: begin
          // ready beats the watchdog when both hit together
          if (bus.md_rdy) begin
            r_wb_data  <= bus.md_result;
            r_wb_exc   <= bus.md_exception;
            r_wb_rd    <= r_rd;
            r_wb_valid <= 1'b1;
            r_state    <= DONE;
          end else if (w_timeout) begin
            r_wb_data  <= '0;
            r_wb_exc   <= 1'b1;
            r_wb_rd    <= r_rd;
            r_wb_valid <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: r_state <= IDLE;
      endcase
    end
  end

  assign bus.md_ctrl_mult = r_mult;
  assign bus.md_ctrl_div  = r_div;
  assign bus.md_opA       = r_opA;
  assign bus.md_opB       = r_opB;
  assign bus.wb_valid     = r_wb_valid;
  assign bus.wb_rd        = r_wb_rd;
  assign bus.wb_data      = r_wb_data;
  assign bus.wb_exception = r_wb_exc;
  assign bus.stall        = w_accept
                          | (r_state == START)
                          | (r_state == WAIT);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: default watchdog instance plus
// a TIMEOUT=4 instance for the watchdog cases.
module tb_multdiv_ctrl;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   n_stall;
  int   n_mul;
  int   n_div;
  int   n_wb;

  multdiv_ctrl_if io ();
  multdiv_ctrl_if io4 ();

  multdiv_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (io)
  );

  multdiv_ctrl #(.TIMEOUT(4)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (io4)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    io.in_valid      = 1'b0;
    io.OP            = 5'd0;
    io.ALUOP         = 5'd0;
    io.rd_in         = 5'd0;
    io.opA           = 32'd0;
    io.opB           = 32'd0;
    io.md_result     = 32'd0;
    io.md_exception  = 1'b0;
    io.md_rdy        = 1'b0;
    io4.in_valid     = 1'b0;
    io4.OP           = 5'd0;
    io4.ALUOP        = 5'd0;
    io4.rd_in        = 5'd0;
    io4.opA          = 32'd0;
    io4.opB          = 32'd0;
    io4.md_result    = 32'd0;
    io4.md_exception = 1'b0;
    io4.md_rdy       = 1'b0;
  endtask

  task automatic issue(input logic [4:0] aluop,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] rd);
    io.in_valid = 1'b1;
    io.OP       = 5'd0;
    io.ALUOP    = aluop;
    io.opA      = a;
    io.opB      = b;
    io.rd_in    = rd;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_in();
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_mult", io.md_ctrl_mult, 0);
    chk("rst_div", io.md_ctrl_div, 0);
    chk("rst_wbv", io.wb_valid, 0);
    chk("rst_wbx", io.wb_exception, 0);
    chk("rst_wbrd", io.wb_rd, 0);
    chk("rst_wbd", io.wb_data, 0);
    chk("rst_opa", io.md_opA, 0);
    chk("rst_opb", io.md_opB, 0);
    chk("rst_stall", io.stall, 0);

    // multiply, fast ready
    step();
    issue(5'b00110, 32'd7, 32'd6, 5'd5);
    #1;
    chk("mul_c0_stall", io.stall, 1);
    chk("mul_c0_mult", io.md_ctrl_mult, 0);
    step();
    io.in_valid = 1'b0;
    #1;
    chk("mul_c1_mult", io.md_ctrl_mult, 1);
    chk("mul_c1_div", io.md_ctrl_div, 0);
    chk("mul_c1_stall", io.stall, 1);
    chk("mul_c1_opa", io.md_opA, 7);
    chk("mul_c1_opb", io.md_opB, 6);
    step();
    io.md_rdy    = 1'b1;
    io.md_result = 32'd42;
    #1;
    chk("mul_c2_mult", io.md_ctrl_mult, 0);
    chk("mul_c2_stall", io.stall, 1);
    step();
    idle_in();
    #1;
    chk("mul_c3_wbv", io.wb_valid, 1);
    chk("mul_c3_rd", io.wb_rd, 5);
    chk("mul_c3_data", io.wb_data, 42);
    chk("mul_c3_exc", io.wb_exception, 0);
    chk("mul_c3_stall", io.stall, 0);
    step();
    chk("mul_c4_wbv", io.wb_valid, 0);
    chk("mul_c4_stall", io.stall, 0);

    // divide by zero, 32 WAIT cycles, junk inputs during WAIT
    n_stall = 0;
    n_mul   = 0;
    n_div   = 0;
    for (int c = 0; c <= 34; c++) begin
      if (c > 0) step();
      io.in_valid     = (c <= 33);
      io.OP           = 5'd0;
      io.ALUOP        = (c == 0) ? 5'b00111 : 5'b00110;
      io.opA          = (c == 0) ? 32'd100 : 32'hdead_beef;
      io.opB          = (c == 0) ? 32'd0 : 32'd5;
      io.rd_in        = (c == 0) ? 5'd9 : 5'd3;
      io.md_rdy       = (c == 33);
      io.md_exception = (c == 33);
      io.md_result    = (c == 33) ? 32'hffff_ffff : 32'd0;
      #1;
      n_stall += int'(io.stall);
      n_mul   += int'(io.md_ctrl_mult);
      n_div   += int'(io.md_ctrl_div);
      if (c == 20) begin
        chk("div_hold_opa", io.md_opA, 100);
        chk("div_hold_opb", io.md_opB, 0);
      end
    end
    chk("div_wbv", io.wb_valid, 1);
    chk("div_rd", io.wb_rd, 9);
    chk("div_exc", io.wb_exception, 1);
    chk("div_data", io.wb_data, 32'hffff_ffff);
    chk("div_done_stall", io.stall, 0);
    chk("div_stall_cycles", n_stall, 34);
    chk("div_pulses", n_div, 1);
    chk("div_mul_pulses", n_mul, 0);
    idle_in();
    step();
    chk("div_after_wbv", io.wb_valid, 0);
    chk("div_after_stall", io.stall, 0);

    // watchdog, TIMEOUT=4, ready never arrives
    n_stall = 0;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) step();
      io4.in_valid = (c == 0);
      io4.ALUOP    = 5'b00110;
      io4.opA      = 32'd3;
      io4.opB      = 32'd4;
      io4.rd_in    = 5'd12;
      #1;
      n_stall += int'(io4.stall);
      if (c == 5) chk("wd_c5_wbv", io4.wb_valid, 0);
    end
    chk("wd_wbv", io4.wb_valid, 1);
    chk("wd_data", io4.wb_data, 0);
    chk("wd_exc", io4.wb_exception, 1);
    chk("wd_rd", io4.wb_rd, 12);
    chk("wd_stall_cycles", n_stall, 6);
    idle_in();
    step();

    // watchdog, ready in the last WAIT cycle wins
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) step();
      io4.in_valid  = (c == 0);
      io4.ALUOP     = 5'b00111;
      io4.opA       = 32'd20;
      io4.opB       = 32'd2;
      io4.rd_in     = 5'd13;
      io4.md_rdy    = (c == 5);
      io4.md_result = (c == 5) ? 32'h1234 : 32'd0;
      #1;
      if (c == 1) chk("wd2_div", io4.md_ctrl_div, 1);
    end
    chk("wd2_wbv", io4.wb_valid, 1);
    chk("wd2_data", io4.wb_data, 32'h1234);
    chk("wd2_exc", io4.wb_exception, 0);
    idle_in();
    step();

    // non-mul/div and invalid instructions
    io.in_valid = 1'b1;
    io.ALUOP    = 5'b00000;
    #1;
    chk("add_stall", io.stall, 0);
    step();
    io.OP    = 5'b00001;
    io.ALUOP = 5'b00110;
    #1;
    chk("op1_stall", io.stall, 0);
    chk("add_mult", io.md_ctrl_mult, 0);
    step();
    io.OP       = 5'd0;
    io.in_valid = 1'b0;
    #1;
    chk("inv_stall", io.stall, 0);
    chk("op1_mult", io.md_ctrl_mult, 0);
    step();
    chk("inv_mult", io.md_ctrl_mult, 0);
    chk("inv_div", io.md_ctrl_div, 0);
    chk("inv_wbv", io.wb_valid, 0);

    // back-to-back mul then div
    n_wb = 0;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) step();
      idle_in();
      if (c == 0) issue(5'b00110, 32'd1, 32'd11, 5'd1);
      if (c == 3 || c == 4) issue(5'b00111, 32'd44, 32'd2, 5'd2);
      io.md_rdy    = (c == 2) || (c == 6);
      io.md_result = (c == 2) ? 32'd11 : 32'd22;
      #1;
      n_wb += int'(io.wb_valid);
      if (c == 3) begin
        chk("b2b_wb1_rd", io.wb_rd, 1);
        chk("b2b_wb1_data", io.wb_data, 11);
        chk("b2b_c3_stall", io.stall, 0);
      end
      if (c == 4) begin
        chk("b2b_c4_stall", io.stall, 1);
        chk("b2b_c4_div", io.md_ctrl_div, 0);
      end
      if (c == 5) chk("b2b_c5_div", io.md_ctrl_div, 1);
      if (c == 7) begin
        chk("b2b_wb2_v", io.wb_valid, 1);
        chk("b2b_wb2_rd", io.wb_rd, 2);
        chk("b2b_wb2_data", io.wb_data, 22);
      end
    end
    chk("b2b_wb_count", n_wb, 2);

    // reset while waiting, late ready must not commit
    step();
    issue(5'b00110, 32'd9, 32'd9, 5'd7);
    step();
    idle_in();
    step();
    step();
    reset = 1'b1;
    step();
    reset        = 1'b0;
    io.md_rdy    = 1'b1;
    io.md_result = 32'd81;
    #1;
    chk("rstw_wbv", io.wb_valid, 0);
    chk("rstw_mult", io.md_ctrl_mult, 0);
    chk("rstw_stall", io.stall, 0);
    chk("rstw_opa", io.md_opA, 0);
    chk("rstw_wbrd", io.wb_rd, 0);
    chk("rstw_wbd", io.wb_data, 0);
    chk("rstw_wbx", io.wb_exception, 0);
    step();
    chk("rstw_late_wbv", io.wb_valid, 0);
    chk("rstw_late_stall", io.stall, 0);
    step();
    chk("rstw_late2_wbv", io.wb_valid, 0);
    idle_in();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequencing controller for the shared multi-cycle multiply/divide unit in the execute stage. It decodes R-type `mul`/`div` instructions from `OP`/`ALUOP` and latches their operands and destination register. It then issues a single start pulse to the mult/div unit, stalls the pipeline until the unit reports ready or a watchdog expires, and presents a one-cycle writeback packet to the register-file write port.

## Interface
Parameters:
- `TIMEOUT`, default 64: maximum number of WAIT cycles before the operation is abandoned with an exception (≥2).

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  a valid instruction occupies the execute stage.
- `OP`  in  5  instruction opcode.
- `ALUOP`  in  5  R-type ALU op field.
- `rd_in`  in  5  destination register.
- `opA`, `opB`  in  32 each  source operands.
- `md_ctrl_mult`  out  1  one-cycle start pulse for multiply.
- `md_ctrl_div`  out  1  one-cycle start pulse for divide.
- `md_opA`, `md_opB`  out  32 each  latched operands, held stable from START through DONE.
- `md_result`  in  32  unit result.
- `md_exception`  in  1  unit exception (overflow or divide by zero); valid with `md_rdy`.
- `md_rdy`  in  1  unit result ready.
- `stall`  out  1  freezes PC, F/D and D/X latches.
- `wb_valid`  out  1  writeback strobe.
- `wb_rd`  out  5  writeback register.
- `wb_data`  out  32  writeback data.
- `wb_exception`  out  1  writeback with exception.

## Operation
- Decode:
  - `is_mul` = `in_valid` & `OP`==00000 & `ALUOP`==00110.
  - `is_div` = `in_valid` & `OP`==00000 & `ALUOP`==00111.
  - `accept` = (state==IDLE) & (`is_mul` | `is_div`).
- States: IDLE, START, WAIT, DONE (2-bit state register).
- IDLE:
  - On `accept`: latch `opA`, `opB`, `rd_in` and the op type, clear the counter, go to START.
  - Otherwise stay in IDLE.
- START:
  - Drive `md_ctrl_mult` or `md_ctrl_div` high, whichever matches the latched op type.
  - `md_rdy` is ignored in this state.
  - Always go to WAIT.
- WAIT:
  - If `md_rdy`: register `wb_data`=`md_result` and `wb_exception`=`md_exception`, go to DONE.
  - Else if counter==`TIMEOUT`-1: register `wb_data`=0 and `wb_exception`=1, go to DONE.
  - Else increment the counter.
  - If `md_rdy` and timeout occur in the same cycle, `md_rdy` wins.
- DONE:
  - `wb_valid`=1 for exactly one cycle, with `wb_rd` = latched rd. An `rd` of 0 is still presented; the register file discards it.
  - Always go to IDLE.
  - Decode inputs are not sampled in DONE.
- `stall` is combinational: `accept` | (state==START) | (state==WAIT).
  - `stall` is low in DONE, so the mul/div instruction leaves X during the writeback cycle.
- Inputs `OP`, `ALUOP`, `opA`, `opB`, `rd_in`, `in_valid` are ignored outside IDLE.
- Counter width: ceil(log2(`TIMEOUT`)) bits; saturating is unnecessary because the counter is bounded by the state exit.
- Reset values:
  - state=IDLE, counter=0, latches=0.
  - `md_ctrl_mult`/`md_ctrl_div`/`wb_valid`/`wb_exception`=0, `wb_rd`=0, `wb_data`=0, `md_opA`/`md_opB`=0.
  - `stall`=0 unless `accept` is true combinationally.
- Reset mid-operation (any state): return to IDLE next edge with no start pulse and no writeback. The abandoned unit result is never committed.

## Timing
- Accept in cycle 0 → START in cycle 1 (start pulse) → WAIT from cycle 2.
- With `md_rdy` first high in WAIT cycle k, DONE follows in cycle k+1 with `wb_valid`.
- Minimum latency is accept to `wb_valid` = 3 cycles (`md_rdy` high in cycle 2, `wb_valid` in cycle 3).
- `stall` is high in cycles 0 through k; it goes low in the DONE cycle.
- Timeout: with `md_rdy` never asserted, WAIT lasts exactly `TIMEOUT` cycles (cycles 2 … `TIMEOUT`+1), and DONE is at cycle `TIMEOUT`+2.
- Back-to-back: a second mul/div presented in X the cycle after DONE is accepted in that IDLE cycle. There is no dead cycle beyond DONE.
- Start pulses never exceed one cycle and never overlap.

## Test plan
- **Multiply, fast ready.** Stimulus: `OP`=0, `ALUOP`=00110, opA=7, opB=6, rd=5; unit raises `md_rdy` with result 42 in the first WAIT cycle. Required: `md_ctrl_mult` high in cycle 1 only; `stall` high in cycles 0–2; `wb_valid`, rd=5, data=42, exc=0 in cycle 3.
- **Divide by zero.** Stimulus: `ALUOP`=00111, opB=0; unit returns `md_rdy`=1 with `md_exception`=1 after 32 WAIT cycles. Required: `md_ctrl_div` pulse only; `wb_exception`=1; `stall` high for 34 cycles.
- **Watchdog.** Stimulus: `TIMEOUT`=4, `md_rdy` held low. Required: DONE in cycle 6 with data=0, exc=1; `md_rdy`=1 in the 4th WAIT cycle (cycle 5) gives the real result instead.
- **Non-mul/div and ignored inputs.** Stimulus: `ALUOP`=00000 add, or `in_valid`=0. Required: no `stall`, no pulse, no `wb_valid`. Also change `opA`/`rd_in` during WAIT: `md_opA` and the writeback rd stay latched values.
- **Back-to-back.** Stimulus: mul then div issued consecutively. Required: div accepted in the cycle after the mul's DONE; two `wb_valid` pulses with the correct rds.
- **Reset in WAIT.** Stimulus: assert `reset` one cycle mid-operation. Required: all outputs 0 next cycle, state IDLE, no `wb_valid`, even if `md_rdy` arrives afterward.
